// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider for the multdiv unit.
// One quotient bit per cycle by shift-and-subtract. The trial subtract is a
// single WIDTH+1-bit add of the inverted divisor with carry-in 1.
// Optional feature macro: DIV_REMAINDER_EN adds the data_remainder output.
// Without it the sign-corrected remainder register and its negation logic
// are absent, and quotient timing does not change.
//
// Timing from a start edge s (ctrl_div sampled while idle):
//   s        : operands latched, busy rises
//   s+1      : PREP takes magnitudes and records signs
//   s+2..    : WIDTH ITER steps
//   s+W+2    : FIX publishes the sign-corrected quotient
//   s+W+3    : DONE retires; data_resultRDY is high for the following cycle
// A zero divisor skips straight to DONE, so the ready pulse follows edge s+1.
// busy is already low in the ready cycle. A ctrl_div sampled at the end of
// that cycle starts the next operation back-to-back.

module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StIter,
        StFix,
        StDone
    } state_e;

    state_e            state_q;
    // q_q holds the dividend; it is shifted out MSB-first as quotient bits enter at bit 0.
    logic [WIDTH-1:0]  q_q;
    logic [WIDTH-1:0]  b_q;
    // Partial remainder. It never exceeds |B| <= 2^(WIDTH-1), so WIDTH bits hold
    // it. The shifted value and the trial difference carry the extra bit.
    logic [WIDTH-1:0]  r_q;
    logic [CntW-1:0]   cnt_q;
    logic              neg_quo_q;
    logic [WIDTH-1:0]  result_q;
    logic              exc_q;
    logic              rdy_q;
    logic              busy_q;
`ifdef DIV_REMAINDER_EN
    logic              neg_rem_q;
    logic [WIDTH-1:0]  rem_out_q;
    logic [WIDTH-1:0]  rem_fix;
`endif

    logic [WIDTH:0]    rem_shift;
    logic [WIDTH:0]    rem_trial;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH-1:0]  quo_fix;

    // Datapath: one shift/trial-subtract step, magnitudes and sign fix-up.
    always_comb begin
        rem_shift = {r_q, q_q[WIDTH-1]};
        // R - {0,|B|} as R + {1,~|B|} + 1; bit WIDTH set means it went negative.
        rem_trial = rem_shift + {1'b1, ~b_q} + (WIDTH+1)'(1);
        // The most-negative value maps to itself, which reads as 2^(WIDTH-1) unsigned.
        a_mag     = q_q[WIDTH-1] ? (~q_q + WIDTH'(1)) : q_q;
        b_mag     = b_q[WIDTH-1] ? (~b_q + WIDTH'(1)) : b_q;
        quo_fix   = neg_quo_q ? (~q_q + WIDTH'(1)) : q_q;
    end

`ifdef DIV_REMAINDER_EN
    // Remainder takes the sign of the dividend.
    always_comb begin
        rem_fix = neg_rem_q ? (~r_q + WIDTH'(1)) : r_q;
    end
`endif

    // Control FSM with registered outputs; synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= StIdle;
            q_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
            neg_rem_q <= 1'b0;
            rem_out_q <= '0;
`endif
        end else begin
            rdy_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ctrl_div) begin
                        q_q    <= data_operandA;
                        b_q    <= data_operandB;
                        busy_q <= 1'b1;
                        if (data_operandB == '0) begin
                            result_q <= '0;
                            exc_q    <= 1'b1;
`ifdef DIV_REMAINDER_EN
                            rem_out_q <= '0;
`endif
                            state_q  <= StDone;
                        end else begin
                            state_q <= StPrep;
                        end
                    end
                end
                StPrep: begin
                    neg_quo_q <= q_q[WIDTH-1] ^ b_q[WIDTH-1];
`ifdef DIV_REMAINDER_EN
                    neg_rem_q <= q_q[WIDTH-1];
`endif
                    q_q       <= a_mag;
                    b_q       <= b_mag;
                    r_q       <= '0;
                    cnt_q     <= '0;
                    state_q   <= StIter;
                end
                StIter: begin
                    // Restore (keep the shifted R) when the trial went negative.
                    r_q   <= rem_trial[WIDTH] ? rem_shift[WIDTH-1:0] : rem_trial[WIDTH-1:0];
                    q_q   <= {q_q[WIDTH-2:0], ~rem_trial[WIDTH]};
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    result_q <= quo_fix;
                    exc_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
                    rem_out_q <= rem_fix;
`endif
                    state_q  <= StDone;
                end
                StDone: begin
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;
`ifdef DIV_REMAINDER_EN
    assign data_remainder = rem_out_q;
`endif

endmodule
